// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// with a valid/ready result handshake, sticky overrun and stall detection.
module period_meter #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 400000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun,
    output logic             stalled
);
    typedef enum logic [1:0] {WAIT_EDGE, MEAS_HIGH, MEAS_LOW, STALL} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    // Counters saturate into STALL at TIMEOUT, so TIMEOUT must fit in CNT_W bits.
    if (TIMEOUT < 2 || (CNT_W < 64 && 64'(TIMEOUT) >= (64'd1 << CNT_W))) begin : g_bad_timeout
        $error("period_meter: TIMEOUT must satisfy 2 <= TIMEOUT < 2**CNT_W");
    end

    state_t           r_state, w_next;
    logic             r_s1, r_s2, r_sprev, r_armed;
    logic [1:0]       r_vld;
    logic [CNT_W-1:0] r_cnt, r_hi;
    logic             w_rise, w_fall, w_timeout, w_done, w_take;

    // r_vld marks when s2 holds a real sample; a rise counts only after s2 was seen low,
    // so a wave already high at reset release needs a genuine low-to-high transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_sprev <= 1'b0;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_s1    <= sig_in;
            r_s2    <= r_s1;
            r_sprev <= r_s2;
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && !r_s2)
                r_armed <= 1'b1;
        end
    end

    assign w_rise    = r_s2 & ~r_sprev & r_armed;
    assign w_fall    = ~r_s2 & r_sprev;
    assign w_timeout = (r_cnt == LAST) & ~w_rise;
    assign w_take    = meas_valid & meas_ready;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= WAIT_EDGE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_EDGE: begin
                if (w_rise)         w_next = MEAS_HIGH;
                else if (w_timeout) w_next = STALL;
            end
            MEAS_HIGH: begin
                if (w_rise)         w_next = MEAS_HIGH;
                else if (w_timeout) w_next = STALL;
                else if (w_fall)    w_next = MEAS_LOW;
            end
            MEAS_LOW: begin
                if (w_rise)         w_next = MEAS_HIGH;
                else if (w_timeout) w_next = STALL;
            end
            STALL: begin
                if (w_rise)         w_next = MEAS_HIGH;
            end
            default:                w_next = WAIT_EDGE;
        endcase
    end

    always_comb begin
        w_done  = 1'b0;
        stalled = 1'b0;
        case (r_state)
            MEAS_HIGH, MEAS_LOW: w_done  = w_rise;
            STALL:               stalled = 1'b1;
            default: ;
        endcase
    end

    // The rise cycle itself counts as cycle 1 of the new period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_hi  <= '0;
        end else if (w_rise) begin
            r_cnt <= CNT_W'(1);
            r_hi  <= CNT_W'(1);
        end else if (w_next == STALL) begin
            r_cnt <= '0;
            r_hi  <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == MEAS_HIGH && !w_fall)
                r_hi <= r_hi + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_done && (!meas_valid || w_take)) begin
            period     <= r_cnt;
            high_time  <= r_hi;
            meas_valid <= 1'b1;
        end else if (w_done) begin
            overrun    <= 1'b1;
        end else if (w_take) begin
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end
endmodule
